// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared widths and ALU opcodes for the datapath slice
package datapath_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/registers.sv
// rtl/registers.sv - 32 x 32 register file, two combinational reads, one clocked write
module registers
    import datapath_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_index,
    input  logic [REG_ADDR_W-1:0] rt_index,
    input  logic [REG_ADDR_W-1:0] rd_index,
    input  logic                  reg_dst,
    input  logic                  reg_write,
    input  logic [DATA_W-1:0]     write_value,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data
);

    logic [DATA_W-1:0]     data [0:NUM_REGS-1];
    logic [REG_ADDR_W-1:0] write_register;

    assign write_register = reg_dst ? rd_index : rt_index;

    // Register 0 is hardwired to zero on the read side as well, so a stray
    // preload of data[0] can never leak onto the operand buses.
    assign rs_data = (rs_index == '0) ? '0 : data[rs_index];
    assign rt_data = (rt_index == '0) ? '0 : data[rt_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data[i] <= '0;
            end
        end else if (reg_write && (write_register != '0)) begin
            data[write_register] <= write_value;
        end
    end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - single-cycle MIPS-style datapath: regfile, sign extend, ALU, write-back mux
module datapath
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] write_data,
    input  logic        ALUScr,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic [3:0]  ALUControl,
    output logic [31:0] ALUResult,
    output logic [31:0] out32,
    output logic [31:0] w_scrB,
    output logic        Zero
);

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] write_back;
    logic              unused_bits;

    // Memory strobes and the opcode field belong to the external control and
    // memory; they pass through this slice without effect.
    assign unused_bits = ^{MemRead, MemWrite, instruction[31:26]};

    assign out32      = {{16{instruction[15]}}, instruction[15:0]};
    assign alu_b      = ALUScr ? out32 : rt_data;
    assign write_back = MemtoReg ? write_data : ALUResult;
    assign w_scrB     = rt_data;

    registers registers_inst (
        .clk         (clk),
        .rst         (rst),
        .rs_index    (instruction[25:21]),
        .rt_index    (instruction[20:16]),
        .rd_index    (instruction[15:11]),
        .reg_dst     (RegDst),
        .reg_write   (RegWrite),
        .write_value (write_back),
        .rs_data     (rs_data),
        .rt_data     (rt_data)
    );

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_AND: ALUResult = rs_data & alu_b;
            ALU_OR:  ALUResult = rs_data | alu_b;
            ALU_ADD: ALUResult = rs_data + alu_b;
            ALU_SUB: ALUResult = rs_data - alu_b;
            ALU_SLT: ALUResult = ($signed(rs_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_NOR: ALUResult = ~(rs_data | alu_b);
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed and random checks of datapath against a behavioural model
module tb_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] write_data;
    logic        ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult, out32, w_scrB;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] m [0:31];

    datapath dut (
        .clk(clk), .rst(rst), .instruction(instruction), .write_data(write_data),
        .ALUScr(ALUScr), .RegWrite(RegWrite), .RegDst(RegDst), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .out32(out32), .w_scrB(w_scrB), .Zero(Zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] imm);
        int signed v;
        v = $signed(imm);
        return v;
    endfunction

    function automatic logic [31:0] exp_a();
        return m[instruction[25:21]];
    endfunction

    function automatic logic [31:0] exp_b();
        return ALUScr ? sext(instruction[15:0]) : m[instruction[20:16]];
    endfunction

    function automatic logic [4:0] exp_dest();
        return RegDst ? instruction[15:11] : instruction[20:16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference register file: cleared asynchronously, written at the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 32'd0;
        end else if (RegWrite && exp_dest() != 5'd0) begin
            m[exp_dest()] = MemtoReg ? write_data : model_alu(ALUControl, exp_a(), exp_b());
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
    end

    // Per-cycle compare of every output and the whole register file.
    always @(negedge clk) begin
        logic [31:0] r;
        int bad;
        r = model_alu(ALUControl, exp_a(), exp_b());
        check("cyc_alu", ALUResult, r);
        check("cyc_zero", {31'd0, Zero}, {31'd0, r == 32'd0});
        check("cyc_out32", out32, sext(instruction[15:0]));
        check("cyc_w_scrB", w_scrB, m[instruction[20:16]]);
        check("cyc_wreg", {27'd0, dut.registers_inst.write_register}, {27'd0, exp_dest()});
        bad = -1;
        for (int i = 31; i >= 1; i--)
            if (dut.registers_inst.data[i] !== m[i]) bad = i;
        if (bad < 0) check("cyc_regs", 32'd0, 32'd0 + 32'(bad + 1));
        else check("cyc_regs", dut.registers_inst.data[bad], m[bad]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [31:0] ins, input logic src, input logic we, input logic dst,
                       input logic m2r, input logic [3:0] op, input logic [31:0] wd);
        instruction = ins; ALUScr = src; RegWrite = we; RegDst = dst;
        MemtoReg = m2r; ALUControl = op; write_data = wd;
        MemRead = m2r; MemWrite = ~we & src;
        #1;
    endtask

    task automatic reset_pulse();
        logic [31:0] any;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        any = 32'd0;
        for (int i = 0; i < 32; i++) any = any | dut.registers_inst.data[i];
        check("async_clear", any, 32'd0);
        #1 rst = 1'b0;
    endtask

    localparam logic [3:0] OPS [0:7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};

    initial begin
        rst = 1'b1;
        set(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'd0);
        #11;
        check("reset_reg17", dut.registers_inst.data[17], 32'd0);
        check("reset_w_scrB", w_scrB, 32'd0);
        rst = 1'b0;

        // Preload data[17]=4 and data[18]=2 through the write-back path.
        tick();
        set({11'd0, 5'd17, 11'd0}, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'd4);
        tick();
        set({11'd0, 5'd18, 11'd0}, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'd2);
        tick();

        set(32'h8C080005, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'hA);
        check("lw_out32", out32, 32'd5);
        check("lw_alu", ALUResult, 32'd5);
        check("lw_wreg", {27'd0, dut.registers_inst.write_register}, 32'd8);
        tick();
        check("lw_data8", dut.registers_inst.data[8], 32'hA);

        set(32'h02324820, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'd0);
        check("add_alu", ALUResult, 32'd6);
        check("add_zero", {31'd0, Zero}, 32'd0);
        check("add_no_bypass", dut.registers_inst.data[9], 32'd0);
        tick();
        check("add_data9", dut.registers_inst.data[9], 32'd6);

        set(32'h02325022, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'd0);
        check("sub_alu", ALUResult, 32'd2);
        tick();
        check("sub_data10", dut.registers_inst.data[10], 32'd2);

        set(32'hAC09000A, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'd0);
        check("sw_alu", ALUResult, 32'd10);
        check("sw_w_scrB", w_scrB, 32'd6);
        tick();
        check("sw_data9_kept", dut.registers_inst.data[9], 32'd6);

        set(32'h02295820, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'd0);
        tick();
        check("dep_data11", dut.registers_inst.data[11], 32'hA);
        set(32'h110B0004, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 32'd0);
        check("beq_alu", ALUResult, 32'd0);
        check("beq_zero", {31'd0, Zero}, 32'd1);

        // Held instruction over several edges: same value rewritten.
        set(32'h02324820, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'd0);
        tick(); tick(); tick();
        check("idem_data9", dut.registers_inst.data[9], 32'd6);

        set({11'd0, 5'd0, 11'd0}, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'hDEAD);
        tick();
        check("r0_data", dut.registers_inst.data[0], 32'd0);
        check("r0_read", w_scrB, 32'd0);

        set(32'h2000FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'd0);
        check("neg_imm", out32, 32'hFFFFFFFF);

        set({11'd0, 5'd12, 11'd0}, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'hFFFFFFFF);
        tick();
        set({11'd0, 5'd13, 11'd0}, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'd1);
        tick();
        set({6'd0, 5'd12, 5'd13, 16'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 32'd0);
        check("slt_neg", ALUResult, 32'd1);
        set({6'd0, 5'd13, 5'd12, 16'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 32'd0);
        check("slt_pos", ALUResult, 32'd0);

        reset_pulse();
        check("rst_data17", dut.registers_inst.data[17], 32'd0);

        for (int n = 0; n < 600; n++) begin
            tick();
            set($urandom, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                1'($urandom_range(0, 3) == 0), OPS[$urandom_range(0, 7)], $urandom);
            if (n % 150 == 149) reset_pulse();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle MIPS-style datapath slice: register file, immediate sign-extender, ALU operand mux, 32-bit ALU and write-back mux.
- Driven by an external control unit through ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg and ALUControl.
- Data memory is external. Load data arrives on write_data; ALUResult (address) and w_scrB (store data) leave the block.

Parameters:
- None. Data width 32, 32 registers and 5-bit register indices are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instruction  input  32  current instruction: [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
- write_data  input  32  external write-back data (memory read data)
- ALUScr  input  1  ALU B source: 0 = rs2 data, 1 = out32
- RegWrite  input  1  register-file write enable
- RegDst  input  1  destination register: 0 = rt, 1 = rd
- MemRead  input  1  memory read strobe; accepted but has no internal effect
- MemWrite  input  1  memory write strobe; accepted but has no internal effect
- MemtoReg  input  1  write-back source: 1 = write_data, 0 = ALUResult
- ALUControl  input  4  ALU operation select
- ALUResult  output  32  ALU result
- out32  output  32  sign-extended instruction[15:0]
- w_scrB  output  32  register read data of rt (store data)
- Zero  output  1  1 when ALUResult == 0

Behaviour:
- Register file is 32 x 32-bit.
  - Internal array is named data[0:31].
  - Internal destination-index signal is named write_register, 5 bits, equal to RegDst ? instruction[15:11] : instruction[20:16].
- Reads are combinational, two ports:
  - rs data = data[instruction[25:21]].
  - rt data = data[instruction[20:16]], driven on w_scrB.
  - Register 0 always reads 0.
- Writes happen on the rising clk edge when RegWrite=1 and rst=0.
  - data[write_register] <= MemtoReg ? write_data : ALUResult.
  - Writes to register 0 are discarded.
- A write and a read of the same register in one cycle: the read returns the old value until the edge, then the new value. No bypass.
- rst=1 clears all 32 registers to 0 immediately, independent of clk. No writes occur while rst=1.
- Outputs are purely combinational; no output registers. During reset, outputs follow the zeroed register file.
- out32 = {{16{instruction[15]}}, instruction[15:0]}.
- ALU operand A = rs data. Operand B = ALUScr ? out32 : rs2 data.
- ALUControl encoding (32-bit, wrap-around, no overflow flag):
  - 0000: AND
  - 0001: OR
  - 0010: ADD
  - 0110: SUB (A-B)
  - 0111: SLT signed (result 1 if A<B, else 0)
  - 1100: NOR
  - any other code: result 0
- Zero = (ALUResult == 32'h0), computed combinationally.
- Latency:
  - ALUResult, Zero, out32 and w_scrB are valid in the same cycle as the inputs.
  - Register write-back becomes visible after the next rising edge.
- Repeated writes of the same value with a held instruction across several edges are idempotent.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100.
  - Width constants: DATA_W=32, REG_ADDR_W=5.
- One sub-module: register file, module "registers", instantiated as registers_inst.
  - It holds data[] and write_register so the bench can preload and inspect them hierarchically.
- ALU, sign extender and muxes stay inline in datapath.

Test Plan:
- Reset/preload: rst=1 for 10 ns -> all registers read 0. Release, preload data[17]=4, data[18]=2.
- LW: instruction=0x8C080005, ALUScr=1, RegDst=0, RegWrite=1, MemtoReg=1, ALUControl=0010, write_data=0xA.
  -> out32=5, ALUResult=5, write_register=8; after one edge data[8]=0x0000000A.
- ADD/SUB: instruction=0x02324820, RegDst=1, ALUScr=0, MemtoReg=0, ALUControl=0010.
  -> ALUResult=6, Zero=0, data[9]=6.
  - Then instruction=0x02325022, ALUControl=0110 -> ALUResult=2, data[10]=2.
- SW: instruction=0xAC09000A, ALUScr=1, RegWrite=0, ALUControl=0010.
  -> ALUResult=10, w_scrB=6 (data[9]). No register changes.
- Dependent ADD then BEQ:
  - instruction=0x02295820 -> data[11]=0xA.
  - Then instruction=0x110B0004, ALUScr=0, RegWrite=0, ALUControl=0110 -> ALUResult=0, Zero=1.
- Corner cases:
  - Write to $0 -> still reads 0.
  - Assert rst mid-run -> registers clear without a clock edge.
  - Negative imm 0xFFFF -> out32=0xFFFFFFFF.
  - SLT with A=-1, B=1 -> 1.
